// File: rtl/basic_rr_sched.sv
// basic_rr_sched: round-robin front end that shares one top_basic datapath
// among NUM_REQ requesters. One operation is in flight at a time: accept,
// issue a start pulse, wait for the datapath valid, then hold the tagged
// result until the consumer takes it.
// Optional feature macro: BASIC_RR_SCHED_TIMEOUT_EN adds a WAIT-state
// watchdog that completes a hung operation with rsp_err=1 after TIMEOUT cycles.

module basic_rr_sched #(
  parameter  int WIDTH   = 8,
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 15,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*WIDTH-1:0] req_c,
  output logic [WIDTH-1:0]         dp_a,
  output logic [WIDTH-1:0]         dp_b,
  output logic [WIDTH-1:0]         dp_c,
  output logic                     dp_start,
  input  logic                     dp_valid,
  input  logic [WIDTH-1:0]         dp_x,
  input  logic [WIDTH-1:0]         dp_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_x,
  output logic [WIDTH-1:0]         rsp_y,
  output logic                     rsp_err,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Elaboration-time guard against parameter values the design cannot honour
  if (NUM_REQ < 2 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("basic_rr_sched: NUM_REQ must be >= 2 and TIMEOUT within 1..255");
  end

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] dp_a_q, dp_a_d;
  logic [WIDTH-1:0] dp_b_q, dp_b_d;
  logic [WIDTH-1:0] dp_c_q, dp_c_d;
  logic             dp_start_q, dp_start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_x_q, rsp_x_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             busy_q, busy_d;

`ifdef BASIC_RR_SCHED_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0] cnt_q, cnt_d;
  logic       rsp_err_q, rsp_err_d;
`endif

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] scan_idx;
  logic           accept;

  // Requester index reached by stepping 'off' places past 'base', wrapped
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDW'(sum);
  endfunction

  // Round-robin search from ptr+1; scanning farthest-first lets the nearest hit win
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = wrap_idx(ptr_q, k);
      if (req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // One-hot ready toward the granted requester, only while idle and out of reset
  always_comb begin
    req_ready = '0;
    accept    = !rst && (state_q == S_IDLE) && grant_found;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant_idx == IDW'(i));
    end
  end

  // Next-state and next-output computation for the scheduler FSM
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    dp_c_d      = dp_c_q;
    dp_start_d  = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_x_d     = rsp_x_q;
    rsp_y_d     = rsp_y_q;
    busy_d      = busy_q;
`ifdef BASIC_RR_SCHED_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dp_a_d     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
          dp_b_d     = req_b[int'(grant_idx)*WIDTH +: WIDTH];
          dp_c_d     = req_c[int'(grant_idx)*WIDTH +: WIDTH];
          id_d       = grant_idx;
          ptr_d      = grant_idx;
          dp_start_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef BASIC_RR_SCHED_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      S_WAIT: begin
        if (dp_valid) begin
          rsp_x_d     = dp_x;
          rsp_y_d     = dp_y;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
`ifdef BASIC_RR_SCHED_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
`ifdef BASIC_RR_SCHED_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_CNT) begin
            rsp_x_d     = '0;
            rsp_y_d     = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything and restarts priority at requester 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDW'(NUM_REQ - 1);
      id_q        <= '0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_c_q      <= '0;
      dp_start_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      dp_c_q      <= dp_c_d;
      dp_start_q  <= dp_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_x_q     <= rsp_x_d;
      rsp_y_q     <= rsp_y_d;
      busy_q      <= busy_d;
    end
  end

`ifdef BASIC_RR_SCHED_TIMEOUT_EN
  // Watchdog counter and error flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 8'd0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign dp_c      = dp_c_q;
  assign dp_start  = dp_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_y     = rsp_y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_basic_rr_sched.sv
// tb_basic_rr_sched: directed checks for basic_rr_sched -- reset values,
// single request, round-robin order, response stall, stale datapath valid,
// watchdog (or hang without it) and asynchronous reset mid-operation.

module tb_basic_rr_sched;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a, req_b, req_c;
  logic [WIDTH-1:0]         dp_a, dp_b, dp_c;
  logic                     dp_start;
  logic                     dp_valid;
  logic [WIDTH-1:0]         dp_x, dp_y;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_x, rsp_y;
  logic                     rsp_err;
  logic                     busy;

  logic [WIDTH-1:0] opA [NUM_REQ];
  logic [WIDTH-1:0] opB [NUM_REQ];
  logic [WIDTH-1:0] opC [NUM_REQ];

  int checkCount = 0;
  int errorCount = 0;

  basic_rr_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_start(dp_start),
    .dp_valid(dp_valid), .dp_x(dp_x), .dp_y(dp_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy)
  );

  // Free-running 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle 2 time units past the rising edge
  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  // Drive the operand buses from the operand tables and set the request mask
  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = opA[i];
      req_b[i*WIDTH +: WIDTH] = opB[i];
      req_c[i*WIDTH +: WIDTH] = opC[i];
    end
    req_valid = mask;
  endtask

  // Accept cycle plus ISSUE cycle; returns in the first WAIT cycle
  task automatic issueOp(input int g, input logic [NUM_REQ-1:0] mask, input bit staleValid);
    applyStimulus(mask);
    #1;
    checkOutput("accept_req_ready", 32'(req_ready), 32'(4'b0001 << g));
    checkOutput("accept_dp_start", 32'(dp_start), 32'd0);
    stepCycle();
    checkOutput("issue_dp_start", 32'(dp_start), 32'd1);
    checkOutput("issue_dp_a", 32'(dp_a), 32'(opA[g]));
    checkOutput("issue_dp_b", 32'(dp_b), 32'(opB[g]));
    checkOutput("issue_dp_c", 32'(dp_c), 32'(opC[g]));
    checkOutput("issue_req_ready", 32'(req_ready), 32'd0);
    checkOutput("issue_busy", 32'(busy), 32'd1);
    if (staleValid) begin
      dp_valid = 1'b1;
      dp_x     = 8'hEE;
      dp_y     = 8'hDD;
    end
    stepCycle();
    dp_valid = 1'b0;
    checkOutput("wait_dp_start", 32'(dp_start), 32'd0);
    checkOutput("wait_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  // From the first WAIT cycle: delayed datapath valid, optional stall, return to IDLE
  task automatic finishOp(input int g, input int waitDelay, input logic [7:0] x,
                          input logic [7:0] y, input int stall);
    rsp_ready = (stall == 0);
    for (int d = 0; d < waitDelay; d++) begin
      stepCycle();
      checkOutput("wait_hold_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    dp_valid = 1'b1;
    dp_x     = x;
    dp_y     = y;
    stepCycle();
    dp_valid = 1'b0;
    dp_x     = 8'h00;
    dp_y     = 8'h00;
    checkOutput("resp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("resp_id", 32'(rsp_id), 32'(g));
    checkOutput("resp_x", 32'(rsp_x), 32'(x));
    checkOutput("resp_y", 32'(rsp_y), 32'(y));
    checkOutput("resp_err", 32'(rsp_err), 32'd0);
    for (int s = 1; s < stall; s++) begin
      stepCycle();
      checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("stall_rsp_id", 32'(rsp_id), 32'(g));
      checkOutput("stall_rsp_x", 32'(rsp_x), 32'(x));
      checkOutput("stall_rsp_y", 32'(rsp_y), 32'(y));
      checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    stepCycle();
    checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  // Hold reset for two edges, checking every output is cleared, then release
  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_dp_a", 32'(dp_a), 32'd0);
    checkOutput("rst_dp_start", 32'(dp_start), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    dp_valid  = 1'b0;
    dp_x      = '0;
    dp_y      = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      opA[i] = 8'(8'h10 + i);
      opB[i] = 8'(8'h20 + i);
      opC[i] = 8'(8'h30 + i);
    end
    opA[2] = 8'h3C;
    opB[2] = 8'h0F;
    opC[2] = 8'hA5;

    $display("[TB] reset and single request from requester 2");
    applyReset();
    issueOp(2, 4'b0100, 1'b0);
    finishOp(2, 0, 8'h5A, 8'hC3, 0);

    $display("[TB] round-robin with all requesters valid");
    applyReset();
    issueOp(0, 4'b1111, 1'b0); finishOp(0, 0, 8'h50, 8'hA0, 0);
    issueOp(1, 4'b1111, 1'b0); finishOp(1, 0, 8'h51, 8'hA1, 0);
    issueOp(2, 4'b1111, 1'b0); finishOp(2, 0, 8'h52, 8'hA2, 0);
    issueOp(3, 4'b1111, 1'b0); finishOp(3, 0, 8'h53, 8'hA3, 0);
    issueOp(0, 4'b1111, 1'b0); finishOp(0, 0, 8'h54, 8'hA4, 0);
    issueOp(1, 4'b1111, 1'b0); finishOp(1, 0, 8'h55, 8'hA5, 0);

    $display("[TB] response stall for 5 cycles");
    issueOp(2, 4'b1111, 1'b0); finishOp(2, 0, 8'h77, 8'h88, 5);
    issueOp(3, 4'b1111, 1'b0); finishOp(3, 0, 8'h99, 8'h11, 0);

    $display("[TB] stale datapath valid during ISSUE");
    issueOp(1, 4'b0010, 1'b1); finishOp(1, 3, 8'h42, 8'h24, 0);

    $display("[TB] datapath never completes");
    rsp_ready = 1'b0;
    issueOp(0, 4'b0001, 1'b0);
    req_valid = '0;
`ifdef BASIC_RR_SCHED_TIMEOUT_EN
    repeat (14) stepCycle();
    checkOutput("to_before_expiry", 32'(rsp_valid), 32'd0);
    stepCycle();
    checkOutput("to_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("to_rsp_err", 32'(rsp_err), 32'd1);
    checkOutput("to_rsp_x", 32'(rsp_x), 32'd0);
    checkOutput("to_rsp_y", 32'(rsp_y), 32'd0);
    checkOutput("to_rsp_id", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1;
    stepCycle();
    checkOutput("to_idle_busy", 32'(busy), 32'd0);
    rsp_ready = 1'b0;
    issueOp(0, 4'b0001, 1'b0);
`else
    repeat (30) stepCycle();
    checkOutput("hang_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("hang_busy", 32'(busy), 32'd1);
`endif

    $display("[TB] asynchronous reset in WAIT with requester 1 pending");
    req_valid = 4'b0011;
    stepCycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_dp_a", 32'(dp_a), 32'd0);
    checkOutput("arst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("post_rst_dp_start", 32'(dp_start), 32'd0);
    issueOp(0, 4'b0011, 1'b0); finishOp(0, 0, 8'h12, 8'h34, 0);
    issueOp(1, 4'b0011, 1'b0); finishOp(1, 0, 8'h56, 8'h78, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
